// File: rtl/xosera_pkg.sv
// Shared Xosera definitions: bus widths, register numbers and host bus FSM states.
package xosera_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned REG_NUM_W = 4;

  // Host-visible register numbers, shared with the register controller.
  typedef enum logic [REG_NUM_W-1:0] {
    XM_SYS_CTRL  = 4'h0,
    XM_INT_CTRL  = 4'h1,
    XM_TIMER     = 4'h2,
    XM_RD_XADDR  = 4'h3,
    XM_WR_XADDR  = 4'h4,
    XM_XDATA     = 4'h5,
    XM_RD_INCR   = 4'h6,
    XM_RD_ADDR   = 4'h7,
    XM_WR_INCR   = 4'h8,
    XM_WR_ADDR   = 4'h9,
    XM_DATA      = 4'hA,
    XM_DATA_2    = 4'hB,
    XM_PIXEL_X   = 4'hC,
    XM_PIXEL_Y   = 4'hD,
    XM_UART      = 4'hE,
    XM_FEATURE   = 4'hF
  } xm_reg_num_t;

  // RELEASE: waiting for chip select to go high; IDLE: armed for the next access.
  typedef enum logic {
    RELEASE = 1'b0,
    IDLE    = 1'b1
  } host_bus_state_t;

endpackage

// File: rtl/cdc_sync_ff.sv
// Multi-flop synchronizer for asynchronous level inputs.
//   clk      : destination clock
//   reset_i  : synchronous active-high reset, loads RESET_VAL into every stage
//   d_i      : asynchronous input
//   q_o      : synchronized output (last stage)
module cdc_sync_ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift chain: stage 0 samples the async input, later stages settle metastability.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        sync_q[i] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/host_bus_if.sv
// Host-side register port: synchronizes the 8-bit host bus chip select, pairs
// even/odd byte writes into 16-bit register write strobes and serves byte reads.
//   clk, reset_i          : clock, synchronous active-high reset
//   bus_cs_n_i            : async chip select (active low)
//   bus_rd_nwr_i          : 1 = read, 0 = write
//   bus_bytesel_i         : 0 = even (high) byte, 1 = odd (low) byte
//   bus_reg_num_i         : register number
//   bus_data_i/o          : host write / read byte
//   bus_data_oe_o         : read data pad output enable
//   reg_write_strobe_o    : one-cycle 16-bit register write
//   reg_read_strobe_o     : one-cycle pulse on odd-byte read
//   reg_num_o, reg_data_o : register number / write word for the strobes
//   reg_data_i            : register read word
module host_bus_if
  import xosera_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 bus_cs_n_i,
  input  logic                 bus_rd_nwr_i,
  input  logic                 bus_bytesel_i,
  input  logic [REG_NUM_W-1:0] bus_reg_num_i,
  input  logic [BYTE_W-1:0]    bus_data_i,
  output logic [BYTE_W-1:0]    bus_data_o,
  output logic                 bus_data_oe_o,
  output logic                 reg_write_strobe_o,
  output logic                 reg_read_strobe_o,
  output logic [REG_NUM_W-1:0] reg_num_o,
  output logic [WORD_W-1:0]    reg_data_o,
  input  logic [WORD_W-1:0]    reg_data_i
);

  logic cs_sync;

  host_bus_state_t      state_q, state_d;
  logic [BYTE_W-1:0]    even_latch_q, even_latch_d;
  logic [BYTE_W-1:0]    bus_data_q, bus_data_d;
  logic                 oe_q, oe_d;
  logic                 wr_strobe_q, wr_strobe_d;
  logic                 rd_strobe_q, rd_strobe_d;
  logic [REG_NUM_W-1:0] reg_num_q, reg_num_d;
  logic [WORD_W-1:0]    reg_data_q, reg_data_d;

  // Resetting to 0 ("selected") keeps a select held across reset from capturing.
  cdc_sync_ff #(
    .WIDTH     (1),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_cs_sync (
    .clk     (clk),
    .reset_i (reset_i),
    .d_i     (bus_cs_n_i),
    .q_o     (cs_sync)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= RELEASE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one capture per select-low period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RELEASE: if (cs_sync)  state_d = IDLE;
      IDLE:    if (!cs_sync) state_d = RELEASE;
      default: state_d = RELEASE;
    endcase
  end

  // Output/datapath next values; bus fields are stable while selected, so they are sampled directly.
  always_comb begin
    even_latch_d = even_latch_q;
    bus_data_d   = bus_data_q;
    oe_d         = oe_q;
    wr_strobe_d  = 1'b0;
    rd_strobe_d  = 1'b0;
    reg_num_d    = reg_num_q;
    reg_data_d   = reg_data_q;
    case (state_q)
      RELEASE: begin
        if (cs_sync) oe_d = 1'b0;
      end
      IDLE: begin
        if (!cs_sync) begin
          if (bus_rd_nwr_i) begin
            bus_data_d = bus_bytesel_i ? reg_data_i[BYTE_W-1:0] : reg_data_i[WORD_W-1:BYTE_W];
            oe_d       = 1'b1;
            if (bus_bytesel_i) begin
              rd_strobe_d = 1'b1;
              reg_num_d   = bus_reg_num_i;
            end
          end else if (!bus_bytesel_i) begin
            even_latch_d = bus_data_i;
          end else begin
            wr_strobe_d = 1'b1;
            reg_num_d   = bus_reg_num_i;
            reg_data_d  = {even_latch_q, bus_data_i};
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      even_latch_q <= '0;
      bus_data_q   <= '0;
      oe_q         <= 1'b0;
      wr_strobe_q  <= 1'b0;
      rd_strobe_q  <= 1'b0;
      reg_num_q    <= '0;
      reg_data_q   <= '0;
    end else begin
      even_latch_q <= even_latch_d;
      bus_data_q   <= bus_data_d;
      oe_q         <= oe_d;
      wr_strobe_q  <= wr_strobe_d;
      rd_strobe_q  <= rd_strobe_d;
      reg_num_q    <= reg_num_d;
      reg_data_q   <= reg_data_d;
    end
  end

  assign bus_data_o         = bus_data_q;
  assign bus_data_oe_o      = oe_q;
  assign reg_write_strobe_o = wr_strobe_q;
  assign reg_read_strobe_o  = rd_strobe_q;
  assign reg_num_o          = reg_num_q;
  assign reg_data_o         = reg_data_q;

endmodule
